mul_wb_buffer: RTL
==================

Name: mul_wb_buffer

Overview:
- Writeback-side consumer of the M-extension result bundle (mul2lsu).
- Queues completed mul/div results in a small FIFO and merges them onto the single register-file write port, with LSU writebacks taking priority.
- Back-pressures the M unit when full, and flags RAW hazards against buffered results to the forwarding unit.

Parameters:
- XLEN, 32, data width.
- DEPTH, 2, number of result entries (power of two, at least 2).
- AW, 5, register address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush from the forwarding unit
- mul_req_i  in  1  valid result from the M unit (mul2lsu.alu_m_req)
- mul_result_i  in  XLEN  result data (mul2lsu.alu_m_result)
- mul_rd_addr_i  in  AW  destination register of the presented result
- mul_stall_o  out  1  result not accepted this cycle; upstream holds it
- lsu_wb_valid_i  in  1  LSU writeback this cycle (priority)
- lsu_wb_rd_addr_i  in  AW  LSU destination register
- lsu_wb_data_i  in  XLEN  LSU writeback data
- wb_valid_o  out  1  register-file write enable
- wb_rd_addr_o  out  AW  register-file write address
- wb_data_o  out  XLEN  register-file write data
- hz_rs1_addr_i  in  AW  rs1 address queried by the forwarding unit
- hz_rs2_addr_i  in  AW  rs2 address queried by the forwarding unit
- mul_hazard_o  out  1  a live buffered entry targets rs1 or rs2

Behaviour:
- State: circular FIFO of DEPTH entries {rd, data, kill}; wrapping rd_ptr and wr_ptr; count of width $clog2(DEPTH+1).
- Reset: FIFO empty, pointers and count 0, all kill bits 0. Outputs follow from the empty state: wb_valid_o=0, mul_stall_o=0, mul_hazard_o=0, wb_rd_addr_o=0, wb_data_o=0.
- Reset mid-operation discards every entry immediately (asynchronous).
- Writeback mux (combinational):
  - lsu_wb_valid_i=1: drive LSU address and data, wb_valid_o=1.
  - Otherwise, FIFO non-empty and head live: drive head rd and data, wb_valid_o=1.
  - Otherwise: wb_valid_o=0 and address/data 0.
- pop when the FIFO is non-empty and either (head kill=1) or (lsu_wb_valid_i=0).
  - A killed head is popped silently, even while the LSU is writing back.
- accept = mul_req_i & ~flush_i & (count<DEPTH | pop).
  - Full-with-pop is a simultaneous push and pop; count is unchanged.
- mul_stall_o = mul_req_i & ~flush_i & (count==DEPTH) & ~pop. This is combinational.
  - The M unit holds its request while stalled, so each result is accepted exactly once.
- Result with rd=0: accepted (no stall) but not written into the FIFO.
- Latency: a result accepted in cycle N becomes the FIFO head in N+1 at the earliest, and is written back in N+1 if the FIFO was empty and the LSU is idle.
- flush_i: the request presented that cycle is dropped and never stalled. Buffered entries are committed state and drain normally; flush does not clear them.
- WAW kill: every buffered entry belongs to an older instruction than a concurrent LSU writeback.
  - When lsu_wb_valid_i=1 and lsu_wb_rd_addr_i!=0, every entry with a matching rd gets kill=1 on that clock edge.
  - A result accepted in the same cycle with the same rd is older than the load and is enqueued with kill=1.
- Same-rd entries inside the FIFO keep program order: the later entry is written back later.
- mul_hazard_o = OR over live (count-valid, kill=0) entries of (rd!=0 & (rd==hz_rs1_addr_i | rd==hz_rs2_addr_i)). A query address of 0 never produces a hit.
- count never exceeds DEPTH and never underflows; pointers wrap modulo DEPTH.

Decomposition:
- Shared package: XLEN/AW defines from the existing defs header, plus a new type_mulwb_entry_s {rd, data, kill} in the M-extension defs.
- Natural sub-module: mul_wb_fifo, a generic DEPTH-entry circular buffer with per-entry kill-by-address and a hazard compare.
- Top level holds the writeback mux and the accept/stall logic.

Test Plan:
- Empty FIFO, LSU idle, mul_req_i=1, rd=5, data=0x0000_0F0F at cycle N -> in N+1: wb_valid_o=1, wb_rd_addr_o=5, wb_data_o=0x0000_0F0F; FIFO empty in N+2.
- LSU valid for 4 cycles while 3 results arrive back-to-back (DEPTH=2) -> third result sees mul_stall_o=1 until the LSU frees; results then appear in order with no duplicates and none lost.
- Full FIFO, LSU drops in the same cycle a new result arrives -> mul_stall_o=0, push+pop, count stays 2.
- Buffered rd=7, LSU writes rd=7 data 0xAAAA_AAAA -> LSU value is written; the entry is later popped silently with no second write to x7; mul_hazard_o for rs1=7 drops after the kill.
- flush_i=1 with mul_req_i=1 rd=3, one entry buffered -> new result dropped, no stall; the buffered entry still writes back.
- mul_req_i with rd=0, and hz_rs1=0 with entries present -> no writeback for x0 and mul_hazard_o=0. Assert rst_n low with 2 entries -> outputs 0 immediately; nothing written after release.

Source files
------------

// File: rtl/mul_wb_buffer_pkg.sv
// mul_wb_buffer_pkg: shared widths and the buffered M-unit result entry type.
package mul_wb_buffer_pkg;
    localparam int DEF_XLEN  = 32;
    localparam int DEF_AW    = 5;
    localparam int DEF_DEPTH = 2;

    typedef struct packed {
        logic [DEF_AW-1:0]   rd;
        logic [DEF_XLEN-1:0] data;
        logic                kill;
    } type_mulwb_entry_s;
endpackage

// File: rtl/mul_wb_fifo.sv
// mul_wb_fifo: circular result buffer with per-entry WAW kill-by-address and RAW hazard compare.
module mul_wb_fifo
    import mul_wb_buffer_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int AW    = DEF_AW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  logic [AW-1:0]   push_rd_i,
    input  logic [XLEN-1:0] push_data_i,
    input  logic            push_kill_i,
    input  logic            pop_i,
    input  logic            kill_en_i,
    input  logic [AW-1:0]   kill_rd_i,
    input  logic [AW-1:0]   hz_rs1_addr_i,
    input  logic [AW-1:0]   hz_rs2_addr_i,
    output logic            empty_o,
    output logic            full_o,
    output logic [AW-1:0]   head_rd_o,
    output logic [XLEN-1:0] head_data_o,
    output logic            head_kill_o,
    output logic            hazard_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]    rd_q   [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0] kill_q, kill_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    off;

    assign empty_o     = count_q == '0;
    assign full_o      = count_q == CW'(DEPTH);
    assign head_rd_o   = rd_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign head_kill_o = kill_q[rd_ptr_q];
    assign rd_ptr_d    = rd_ptr_q + PW'(pop_i);
    assign wr_ptr_d    = wr_ptr_q + PW'(push_i);
    assign count_d     = count_q + CW'(push_i) - CW'(pop_i);

    // an entry is live when its distance from the head is below count and it is not killed
    always_comb begin
        kill_d   = kill_q;
        hazard_o = 1'b0;
        off      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off       = PW'(i) - rd_ptr_q;
            kill_d[i] = kill_q[i] | (kill_en_i & (rd_q[i] == kill_rd_i));
            hazard_o  = hazard_o | ((CW'(off) < count_q) & ~kill_q[i] & (rd_q[i] != '0)
                        & ((rd_q[i] == hz_rs1_addr_i) | (rd_q[i] == hz_rs2_addr_i)));
        end
        if (push_i) kill_d[wr_ptr_q] = push_kill_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            kill_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            kill_q   <= kill_d;
            if (push_i) begin
                rd_q[wr_ptr_q]   <= push_rd_i;
                data_q[wr_ptr_q] <= push_data_i;
            end
        end
    end
endmodule

// File: rtl/mul_wb_buffer.sv
// mul_wb_buffer: queues M-unit results and merges them onto the register-file write port behind LSU writebacks.
module mul_wb_buffer
    import mul_wb_buffer_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            mul_req_i,
    input  logic [XLEN-1:0] mul_result_i,
    input  logic [AW-1:0]   mul_rd_addr_i,
    output logic            mul_stall_o,
    input  logic            lsu_wb_valid_i,
    input  logic [AW-1:0]   lsu_wb_rd_addr_i,
    input  logic [XLEN-1:0] lsu_wb_data_i,
    output logic            wb_valid_o,
    output logic [AW-1:0]   wb_rd_addr_o,
    output logic [XLEN-1:0] wb_data_o,
    input  logic [AW-1:0]   hz_rs1_addr_i,
    input  logic [AW-1:0]   hz_rs2_addr_i,
    output logic            mul_hazard_o
);
    logic            empty, full, head_kill, head_live, pop, accept, kill_en;
    logic [AW-1:0]   head_rd;
    logic [XLEN-1:0] head_data;

    // killed heads drain even while the LSU owns the port
    assign kill_en     = lsu_wb_valid_i & (lsu_wb_rd_addr_i != '0);
    assign head_live   = ~empty & ~head_kill;
    assign pop         = ~empty & (head_kill | ~lsu_wb_valid_i);
    assign accept      = mul_req_i & ~flush_i & (~full | pop);
    assign mul_stall_o = mul_req_i & ~flush_i & full & ~pop;

    always_comb begin
        wb_valid_o   = lsu_wb_valid_i | head_live;
        wb_rd_addr_o = lsu_wb_valid_i ? lsu_wb_rd_addr_i : head_live ? head_rd : '0;
        wb_data_o    = lsu_wb_valid_i ? lsu_wb_data_i : head_live ? head_data : '0;
    end

    mul_wb_fifo #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (accept & (mul_rd_addr_i != '0)),
        .push_rd_i    (mul_rd_addr_i),
        .push_data_i  (mul_result_i),
        .push_kill_i  (kill_en & (mul_rd_addr_i == lsu_wb_rd_addr_i)),
        .pop_i        (pop),
        .kill_en_i    (kill_en),
        .kill_rd_i    (lsu_wb_rd_addr_i),
        .hz_rs1_addr_i(hz_rs1_addr_i),
        .hz_rs2_addr_i(hz_rs2_addr_i),
        .empty_o      (empty),
        .full_o       (full),
        .head_rd_o    (head_rd),
        .head_data_o  (head_data),
        .head_kill_o  (head_kill),
        .hazard_o     (mul_hazard_o)
    );
endmodule
